// File: rtl/sram_demo_pkg.sv
// Shared definitions for the SRAM counter-demo writer and readback checker.
// Contents:
//   LfsrTaps    - feedback tap mask for the 8-bit Fibonacci LFSR (bits 7,5,4,3)
//   SeedZeroSub - value loaded instead of an all-zero seed (zero is a lock-up state)
//   state_e     - readback checker FSM encoding
//   lfsr_next() - one LFSR step: shift left, new bit0 = parity of tapped bits
//   lfsr_seed() - seed with zero substitution applied
// The writer and the checker both use these, so the two sequences cannot diverge.
package sram_demo_pkg;

  localparam logic [7:0] LfsrTaps    = 8'b1011_1000;
  localparam logic [7:0] SeedZeroSub = 8'h01;

  typedef enum logic [2:0] {
    StIdle,
    StCrst,
    StSettle,
    StSample,
    StClkHi,
    StClkLo,
    StFinish
  } state_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LfsrTaps)};
  endfunction

  function automatic logic [7:0] lfsr_seed(input logic [7:0] seed);
    return (seed == 8'h00) ? SeedZeroSub : seed;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR used to generate the SRAM test pattern.
// Ports:
//   clk_i   - clock
//   rst_ni  - synchronous active-low reset; register returns to SeedZeroSub
//   load_i  - load seed_i (zero seed replaced by SeedZeroSub); has priority over step_i
//   step_i  - advance the sequence by one step
//   seed_i  - seed value
//   q_o     - current LFSR state
module lfsr8
  import sram_demo_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [7:0] seed_i,
  output logic [7:0] q_o
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= SeedZeroSub;
    end else if (load_i) begin
      lfsr_q <= lfsr_seed(seed_i);
    end else if (step_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/sram_readback_checker.sv
// Read-side companion to the SRAM counter-demo pattern writer. Drives the external
// address counter through every location with WE_BAR held high, samples the 8-bit word
// {CHIP2_DATA, CHIP1_DATA} after a settle delay, and compares it with the LFSR sequence
// regenerated from SEED.
// Ports:
//   CLK, RST        - clock; synchronous active-low reset
//   START           - rising edge (while idle) starts one pass
//   SEED            - LFSR seed, captured at start
//   COUNTER_CLK     - external address counter clock (counter advances on its rising edge)
//   COUNTER_RST     - external address counter reset, active high
//   WE_BAR          - SRAM write enable, always inactive (1)
//   CHIP1_DATA      - low nibble from SRAM chip 1
//   CHIP2_DATA      - high nibble from SRAM chip 2
//   BUSY, DONE      - pass in progress / pass complete (DONE held until next start)
//   PASS            - valid with DONE; 1 iff no mismatches
//   ERR_COUNT       - saturating mismatch count
//   FIRST_ERR_ADDR  - address of the first mismatch
//   LED_OUT         - {expected, sampled} while busy; ERR_COUNT when done
// All outputs are registered; CHIP*_DATA only reaches outputs through registers.
module sram_readback_checker
  import sram_demo_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned CRST_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned PULSE_CYCLES  = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [7:0]           SEED,
  output logic                 COUNTER_CLK,
  output logic                 COUNTER_RST,
  output logic                 WE_BAR,
  input  logic [3:0]           CHIP1_DATA,
  input  logic [3:0]           CHIP2_DATA,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [15:0]          ERR_COUNT,
  output logic [ADDR_BITS-1:0] FIRST_ERR_ADDR,
  output logic [15:0]          LED_OUT
);

  // Phase counters share one 8-bit register; each phase ends on its "last" value.
  localparam logic [7:0] CrstLast   = 8'(CRST_CYCLES - 1);
  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] PulseLast  = 8'(PULSE_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] AddrLast = {ADDR_BITS{1'b1}};

  state_e                 state_q;
  logic [7:0]             cnt_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   start_q;
  logic                   counter_clk_q;
  logic                   counter_rst_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pass_q;
  logic [15:0]            err_count_q;
  logic [ADDR_BITS-1:0]   first_err_addr_q;
  logic [15:0]            led_q;

  logic                   start_edge;
  logic                   lfsr_load;
  logic                   lfsr_step;
  logic [7:0]             lfsr_q;
  logic [7:0]             rd_data;
  logic                   mismatch;

  assign start_edge = START & ~start_q;
  // Start edges are only acted on in idle, so edges during a pass are ignored.
  assign lfsr_load  = (state_q == StIdle) && start_edge;
  assign lfsr_step  = (state_q == StSample);
  assign rd_data    = {CHIP2_DATA, CHIP1_DATA};
  assign mismatch   = (rd_data != lfsr_q);

  lfsr8 u_lfsr (
    .clk_i  (CLK),
    .rst_ni (RST),
    .load_i (lfsr_load),
    .step_i (lfsr_step),
    .seed_i (SEED),
    .q_o    (lfsr_q)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q          <= StIdle;
      cnt_q            <= 8'd0;
      addr_q           <= '0;
      // Treat START as already high so a level held through reset is not an edge.
      start_q          <= 1'b1;
      counter_clk_q    <= 1'b0;
      counter_rst_q    <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= 16'h0000;
      first_err_addr_q <= '0;
      led_q            <= 16'h0000;
    end else begin
      start_q <= START;
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            state_q          <= StCrst;
            cnt_q            <= 8'd0;
            busy_q           <= 1'b1;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= 16'h0000;
            first_err_addr_q <= '0;
            led_q            <= 16'h0000;
            counter_rst_q    <= 1'b1;
          end
        end

        StCrst: begin
          if (cnt_q == CrstLast) begin
            counter_rst_q <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= 8'd0;
            state_q       <= StSettle;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        // SRAM read access time after the address has changed.
        StSettle: begin
          if (cnt_q == SettleLast) begin
            cnt_q   <= 8'd0;
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        StSample: begin
          led_q <= {lfsr_q, rd_data};
          if (mismatch) begin
            if (err_count_q != 16'hFFFF) begin
              err_count_q <= err_count_q + 16'd1;
            end
            if (err_count_q == 16'h0000) begin
              first_err_addr_q <= addr_q;
            end
          end
          cnt_q <= 8'd0;
          if (addr_q == AddrLast) begin
            state_q <= StFinish;
          end else begin
            counter_clk_q <= 1'b1;
            state_q       <= StClkHi;
          end
        end

        StClkHi: begin
          if (cnt_q == PulseLast) begin
            counter_clk_q <= 1'b0;
            cnt_q         <= 8'd0;
            state_q       <= StClkLo;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        // The external counter has already advanced on the rising edge; mirror it here.
        StClkLo: begin
          if (cnt_q == PulseLast) begin
            addr_q  <= addr_q + 1'b1;
            cnt_q   <= 8'd0;
            state_q <= StSettle;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        // err_count_q already includes the final sample here.
        StFinish: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_count_q == 16'h0000);
          led_q   <= err_count_q;
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign COUNTER_CLK    = counter_clk_q;
  assign COUNTER_RST    = counter_rst_q;
  assign WE_BAR         = 1'b1;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign PASS           = pass_q;
  assign ERR_COUNT      = err_count_q;
  assign FIRST_ERR_ADDR = first_err_addr_q;
  assign LED_OUT        = led_q;

endmodule

// File: tb/tb_sram_readback_checker.sv
// Bench for sram_readback_checker: behavioural external counter + SRAM, table of passes,
// scoreboard of expected end-of-pass results, plus start/reset/saturation sequences.
module tb_sram_readback_checker;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  seed;
  logic        cclk, crst, we_bar;
  logic [3:0]  c1, c2;
  logic        busy, done, pass;
  logic [15:0] err;
  logic [7:0]  first;
  logic [15:0] led;

  logic        start2;
  logic        cclk2, crst2, we_bar2;
  logic        busy2, done2, pass2;
  logic [15:0] err2;
  logic [1:0]  first2;
  logic [15:0] led2;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem   [256];
  logic [7:0] model [256];
  logic [7:0] ext_addr;

  bit mon_en = 0;
  int crst_cycles, cclk_pulses, we_low;

  typedef struct {
    logic        pass;
    logic [15:0] err;
    logic [7:0]  first;
    logic [15:0] led;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [7:0]  seed;
    logic [7:0]  mem_seed;
    int          ca;
    int          cb;
    logic        pass;
    logic [15:0] err;
    logic [7:0]  first;
    logic [15:0] led;
  } vec_t;
  vec_t vecs[5];

  sram_readback_checker #(.ADDR_BITS(8)) dut (
    .CLK(clk), .RST(rst), .START(start), .SEED(seed),
    .COUNTER_CLK(cclk), .COUNTER_RST(crst), .WE_BAR(we_bar),
    .CHIP1_DATA(c1), .CHIP2_DATA(c2),
    .BUSY(busy), .DONE(done), .PASS(pass), .ERR_COUNT(err),
    .FIRST_ERR_ADDR(first), .LED_OUT(led)
  );

  // Small instance whose SRAM always reads 8'h00.
  sram_readback_checker #(.ADDR_BITS(2)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .SEED(8'h01),
    .COUNTER_CLK(cclk2), .COUNTER_RST(crst2), .WE_BAR(we_bar2),
    .CHIP1_DATA(4'h0), .CHIP2_DATA(4'h0),
    .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_COUNT(err2),
    .FIRST_ERR_ADDR(first2), .LED_OUT(led2)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // External address counter and SRAM read path.
  always @(posedge cclk or posedge crst) begin
    if (crst) ext_addr <= 8'd0;
    else      ext_addr <= ext_addr + 8'd1;
  end
  assign c1 = mem[ext_addr][3:0];
  assign c2 = mem[ext_addr][7:4];

  function automatic logic [7:0] nxt(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (mon_en) begin
      if (crst) crst_cycles++;
      if (we_bar !== 1'b1) we_low++;
    end
  end

  // Each counter pulse follows a sample; the word just sampled sits at ext_addr-1.
  always @(posedge cclk) begin
    logic [7:0] la;
    cclk_pulses++;
    #1;
    if (mon_en) begin
      la = ext_addr - 8'd1;
      check("led_live", {16'h0, led}, {16'h0, model[la], mem[la]});
    end
  end

  task automatic preload(input logic [7:0] s, input int ca, input int cb);
    logic [7:0] v;
    v = s;
    for (int i = 0; i < 256; i++) begin
      model[i] = v;
      mem[i]   = v;
      v        = nxt(v);
    end
    if (ca >= 0) mem[ca][0] = ~mem[ca][0];
    if (cb >= 0) mem[cb][0] = ~mem[cb][0];
  endtask

  task automatic start_pass(input logic [7:0] s, input bit push, input exp_t e);
    int n;
    seed  = s;
    start = 0;
    @(negedge clk);
    crst_cycles = 0;
    cclk_pulses = 0;
    we_low      = 0;
    start = 1;
    if (push) sb_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (!busy && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("busy_rise", {31'h0, busy}, 32'h1);
  endtask

  task automatic finish_pass();
    int   n;
    exp_t e;
    n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'h0, 32'h1);
      return;
    end
    e = sb_q.pop_front();
    if (done !== 1'b1) begin
      check("done_timeout", {31'h0, done}, 32'h1);
      return;
    end
    check("pass",        {31'h0, pass},  {31'h0, e.pass});
    check("err_count",   {16'h0, err},   {16'h0, e.err});
    check("first_err",   {24'h0, first}, {24'h0, e.first});
    check("led_done",    {16'h0, led},   {16'h0, e.led});
    check("busy_done",   {31'h0, busy},  32'h0);
    check("crst_cycles", crst_cycles,    32'd4);
    check("cclk_pulses", cclk_pulses,    32'd255);
    check("we_low",      we_low,         32'd0);
  endtask

  initial begin
    exp_t e;
    int   n;

    vecs[0] = '{8'd23,  8'd23,  -1,  -1,  1'b1, 16'd0, 8'd0,   16'd0};
    vecs[1] = '{8'd23,  8'd23,   5,  200, 1'b0, 16'd2, 8'd5,   16'd2};
    vecs[2] = '{8'h00,  8'h01,  -1,  -1,  1'b1, 16'd0, 8'd0,   16'd0};
    vecs[3] = '{8'hA5,  8'hA5,   0,  255, 1'b0, 16'd2, 8'd0,   16'd2};
    vecs[4] = '{8'h3C,  8'h3C,  255, -1,  1'b0, 16'd1, 8'd255, 16'd1};

    rst    = 0;
    start  = 1;
    start2 = 0;
    seed   = 8'h00;
    preload(8'd23, -1, -1);
    repeat (3) @(negedge clk);

    check("rst_cclk",  {31'h0, cclk},   32'h0);
    check("rst_crst",  {31'h0, crst},   32'h0);
    check("rst_we",    {31'h0, we_bar}, 32'h1);
    check("rst_busy",  {31'h0, busy},   32'h0);
    check("rst_done",  {31'h0, done},   32'h0);
    check("rst_pass",  {31'h0, pass},   32'h0);
    check("rst_err",   {16'h0, err},    32'h0);
    check("rst_first", {24'h0, first},  32'h0);
    check("rst_led",   {16'h0, led},    32'h0);

    // START already high at reset release must not launch a pass.
    mon_en = 1;
    rst    = 1;
    repeat (10) @(negedge clk);
    check("no_start_held", {31'h0, busy}, 32'h0);
    check("no_crst_held",  {31'h0, crst}, 32'h0);

    // Fresh edge starts a pass; a second edge mid-pass changes nothing.
    e = '{1'b1, 16'd0, 8'd0, 16'd0};
    start_pass(8'd23, 1'b1, e);
    repeat (20) @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1;
    repeat (3) @(negedge clk);
    check("midpass_busy", {31'h0, busy}, 32'h1);
    check("midpass_crst", {31'h0, crst}, 32'h0);
    finish_pass();

    for (int i = 0; i < 5; i++) begin
      preload(vecs[i].mem_seed, vecs[i].ca, vecs[i].cb);
      e = '{vecs[i].pass, vecs[i].err, vecs[i].first, vecs[i].led};
      start_pass(vecs[i].seed, 1'b1, e);
      finish_pass();
    end

    // Reset in the middle of a pass at address 100.
    preload(8'd23, 5, -1);
    start_pass(8'd23, 1'b0, e);
    n = 0;
    while (ext_addr !== 8'd100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_addr100", {24'h0, ext_addr}, 32'd100);
    check("err_before_rst", {16'h0, err}, 32'd1);
    rst = 0;
    @(posedge clk);
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_cclk", {31'h0, cclk}, 32'h0);
    check("midrst_err",  {16'h0, err},  32'h0);
    check("midrst_crst", {31'h0, crst}, 32'h0);
    @(negedge clk);
    rst = 1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", {31'h0, busy}, 32'h0);
    e = '{1'b0, 16'd1, 8'd5, 16'd1};
    start_pass(8'd23, 1'b1, e);
    finish_pass();

    // Four-location instance, every read wrong.
    start2 = 0;
    @(negedge clk);
    start2 = 1;
    n = 0;
    while (done2 !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("d2_done",  {31'h0, done2},  32'h1);
    check("d2_err",   {16'h0, err2},   32'd4);
    check("d2_first", {30'h0, first2}, 32'd0);
    check("d2_pass",  {31'h0, pass2},  32'h0);
    check("d2_led",   {16'h0, led2},   32'd4);
    check("d2_we",    {31'h0, we_bar2}, 32'h1);
    check("d2_cclk",  {31'h0, cclk2},  32'h0);

    // Saturation: preset the count during counter reset, then four more errors.
    start2 = 0;
    @(negedge clk);
    start2 = 1;
    n = 0;
    while (crst2 !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("d2_crst", {31'h0, crst2}, 32'h1);
    force dut2.err_count_q = 16'hFFFE;
    @(negedge clk);
    release dut2.err_count_q;
    check("d2_preset", {16'h0, err2}, 32'h0000FFFE);
    n = 0;
    while (done2 !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("d2_sat_done",  {31'h0, done2},  32'h1);
    check("d2_sat_err",   {16'h0, err2},   32'h0000FFFF);
    check("d2_sat_led",   {16'h0, led2},   32'h0000FFFF);
    check("d2_sat_pass",  {31'h0, pass2},  32'h0);
    check("d2_sat_first", {30'h0, first2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
